// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus between requesters, the write-back controller and the register file port.
// Latency: none; this is a bundle of wires. The request side is combinational and the write side is registered by the controller.
// Backpressure: a requester holds valid, addr and data until its ready bit is high.
interface regfile_wb_ctrl_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   rf_wr_en;
    logic [ADDR_W-1:0]      rf_w1;
    logic [DATA_W-1:0]      rf_data;

    // Controller side: consumes requests and drives the register file port.
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_wr_en, rf_w1, rf_data
    );

    // Environment side: requesters plus register file.
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_wr_en, rf_w1, rf_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Round-robin write-back arbiter for a single register file write port, with a pending-write scoreboard.
// Latency: the grant is combinational and the write reaches the rf port 1 cycle after acceptance. Busy flags are read combinationally from registered state.
// Backpressure: req_ready is given to at most one valid requester per cycle. Losers hold their request. Reset forces every ready bit low.
module regfile_wb_ctrl #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_ctrl_if.slave  wb,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] chk_r1,
    input  logic [ADDR_W-1:0] chk_r2,
    output logic              busy_r1,
    output logic              busy_r2
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [ADDR_W-1:0] rf_w1_q, rf_w1_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic [NREQ-1:0]   win;
    logic              found;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  gnt_idx;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin scan starting at rr_ptr: the first valid requester wins.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && wb.req_valid[cand]) begin
                win[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

    // A grant raised during reset would be lost, so ready is held low then.
    assign wb.req_ready = rst ? '0 : win;
    assign grant        = found & ~rst;
    assign sel_addr     = wb.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data     = wb.req_data[gnt_idx*DATA_W +: DATA_W];

    // Next-state for the pointer and the output stage. Writes to x0 are accepted but never enabled.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_wr_en_d = 1'b0;
        rf_w1_d    = rf_w1_q;
        rf_data_d  = rf_data_q;
        if (grant) begin
            rr_ptr_d   = PTR_W'((int'(gnt_idx) + 1) % NREQ);
            rf_wr_en_d = (sel_addr != '0);
            rf_w1_d    = sel_addr;
            rf_data_d  = sel_data;
        end
    end

    // Scoreboard: clear on the regfile write edge and set on reservation. A set wins a same-edge clear because it is a newer pending write.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rf_wr_en_q && (rf_w1_q == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset. Reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rf_wr_en_q <= 1'b0;
            rf_w1_q    <= '0;
            rf_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_w1_q    <= rf_w1_d;
            rf_data_q  <= rf_data_d;
            busy_q     <= busy_d;
        end
    end

    assign wb.rf_wr_en = rf_wr_en_q;
    assign wb.rf_w1    = rf_w1_q;
    assign wb.rf_data  = rf_data_q;

    // No bypass: a register reads busy until the edge that writes it.
    assign busy_r1 = busy_q[chk_r1];
    assign busy_r2 = busy_q[chk_r2];
endmodule
